imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time loader that fills the processor's 32-byte instruction memory from an external byte stream, then releases the core. It sits directly upstream of the single-cycle MIPS-lite datapath. It owns the instruction store and provides the big-endian 32-bit fetch port the datapath reads with `pc[4:0]`. The core must not execute until `cpu_run` is high.

## Interface
Parameters:
- `IMEM_BYTES`, 32: instruction store depth in bytes. Fixed; it must match the 5-bit fetch address.

Ports:
- `clk` input 1: single clock. All state updates on posedge.
- `reset` input 1: asynchronous, active-high.
- `in_valid` input 1: a stream byte is presented.
- `in_data` input 8: stream byte.
- `in_ready` output 1: the loader accepts a byte this cycle.
- `rd_addr` input 5: fetch byte address (`pc[4:0]`).
- `instr` output 32: fetched word.
- `done` output 1: load completed successfully.
- `cpu_run` output 1: core enable. Equal to `done`.
- `err` output 1: load failed. Sticky until reset.

## Operation
- A transfer occurs on a posedge where `in_valid && in_ready`.
- Stream format: one length byte N, then N instruction bytes. Bytes are written in order to `mem[0..N-1]`; each 4-byte group is big-endian (MSB first).
- N is legal only when 4 ≤ N ≤ 32 and N[1:0] == 0. Any other N goes to ERR.
- States:
  - LEN: `in_ready=1`. On a transfer, latch N and clear the byte counter. Go to DATA if N is legal, else ERR.
  - DATA: `in_ready=1`. Each transfer writes `mem[cnt] <= in_data` and increments `cnt`. The transfer with `cnt == N-1` moves to CSUM if the macro is defined, else to DONE.
  - CSUM (macro only): see Configuration.
  - DONE: `in_ready=0`, `done=1`. Stays here until reset; further input is ignored.
  - ERR: `in_ready=0`, `err=1`. Stays here until reset.
- Bytes not written by a load stay zero, and zero decodes as a nop.
- Fetch: `instr = {mem[a], mem[a+1], mem[a+2], mem[a+3]}` with `a = rd_addr`. The additions are 5-bit and wrap, so `rd_addr=30` returns `{mem[30], mem[31], mem[0], mem[1]}`.
- Fetch is always live and reads current contents, including during a load.
- `in_valid` low in LEN or DATA means the loader waits. There is no timeout.

## Timing
- Reset values:
  - state LEN, `cnt=0`, N=0, running sum 0;
  - all `mem` bytes 0;
  - `in_ready=1` (LEN), `done=0`, `cpu_run=0`, `err=0`;
  - `instr=0`.
- Reset asserted mid-load aborts the load, clears memory, and returns to LEN. Nothing from the partial load survives.
- A write is visible on `instr` in the cycle after its transfer edge. The fetch path is combinational from `rd_addr` and `mem`.
- `done`, `cpu_run` and `err` are registered. They rise on the edge that performs the final transfer (the last data byte, or the checksum byte when the macro is defined). They are high in the following cycle.
- `in_ready` is a function of state only and never depends on `in_valid`. The loader therefore accepts one byte per cycle at most, with no combinational loop.
- Minimum load time with no stalls: N+1 cycles, or N+2 with the checksum.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - An 8-bit running sum of all N data bytes (mod 256) is kept.
  - After the last data byte the loader enters CSUM with `in_ready=1` and accepts one checksum byte C.
  - If `(sum + C)[7:0] == 0` it goes to DONE, else to ERR.
- Undefined: there is no CSUM state and no sum register. The last data byte goes straight to DONE.

## Structure
- Package `imem_loader_pkg`:
  - state enum: LEN, DATA, CSUM, DONE, ERR;
  - `IMEM_BYTES = 32`;
  - `IMEM_AW = 5`.
- One sub-module, `imem_byte_array`: 32×8 storage with async-reset clear, one write port (`we`, `waddr`, `wdata`), and the combinational big-endian 4-byte wrap-around read port.
- `imem_loader` contains the FSM, counter, length check and checksum, and instantiates `imem_byte_array`.

## Test plan
- Reset, then no input → `in_ready=1`, `done=0`, `err=0`, `instr=0` for every `rd_addr`.
- Stream `08 20 04 00 05 00 85 30 20` with no gaps, macro undefined → `done` and `cpu_run` high after 9 transfers. `rd_addr=0` gives `20040005`, `rd_addr=4` gives `00853020`, `rd_addr=8` gives `00000000`.
- Length byte `06`, then `00`, then `21` → ERR after the first transfer; `err=1`, `in_ready=0`, and later bytes are ignored.
- Macro defined, stream `04 01 02 03 04 F6` → DONE. Same stream with a final `F5` → ERR. `instr` at 0 = `01020304` in both cases.
- Full 32-byte load of bytes `00..1F`, then `rd_addr=30` → `instr=1E1F0001`. Random `in_valid` gaps produce the same final contents.
- Assert `reset` after 3 data bytes of an `08` load → memory is all zero, state is LEN, and a fresh `04 AA BB CC DD` gives `instr(0)=AABBCCDD`.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the boot-time instruction
//                memory loader (state encoding, store geometry, length check).
//  Options     : IMEM_LOADER_CHECKSUM_EN enables the trailing checksum byte.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int IMEM_BYTES = 32;
    localparam int IMEM_AW    = 5;

    // Loader states; CSUM is only reachable when the checksum option is built in
    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // A length byte is usable only if it is a whole number of words that fits
    function automatic logic len_is_legal(input logic [7:0] n);
        return (n >= 8'd4) && (n <= 8'd32) && (n[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_byte_array.sv
`default_nettype none
// ============================================================================
//  Module      : imem_byte_array
//  Description : 32 x 8 instruction store. Cleared by reset, one write port,
//                combinational big-endian 4-byte read with 5-bit wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_byte_array
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [IMEM_AW-1:0] waddr,
    input  logic [7:0]         wdata,
    input  logic [IMEM_AW-1:0] raddr,
    output logic [31:0]        rdata
);

    logic [7:0]         mem_q [IMEM_BYTES];
    logic [7:0]         mem_d [IMEM_BYTES];
    logic [IMEM_AW-1:0] addr1;
    logic [IMEM_AW-1:0] addr2;
    logic [IMEM_AW-1:0] addr3;

    // Next memory image: unchanged except for the single written byte
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage; reset wipes every byte so a partial load never survives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IMEM_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Byte addresses of the fetched word; 5-bit adds wrap past the top of the store
    always_comb begin
        addr1 = raddr + IMEM_AW'(1);
        addr2 = raddr + IMEM_AW'(2);
        addr3 = raddr + IMEM_AW'(3);
        rdata = {mem_q[raddr], mem_q[addr1], mem_q[addr2], mem_q[addr3]};
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot loader that fills the 32-byte instruction store from a
//                length-prefixed byte stream, then raises cpu_run. Provides
//                the big-endian fetch port addressed by pc[4:0].
//  Options     : IMEM_LOADER_CHECKSUM_EN - expect one checksum byte after the
//                data; load succeeds only if (sum of data + checksum) mod 256
//                is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int IMEM_BYTES = 32   // fixed: must match the 5-bit fetch address
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic [4:0]  rd_addr,
    output logic [31:0] instr,
    output logic        done,
    output logic        cpu_run,
    output logic        err
);

    import imem_loader_pkg::*;

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] cnt_q,   cnt_d;
    logic [7:0]         len_q,   len_d;
    logic               done_q,  done_d;
    logic               err_q,   err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         sum_q,   sum_d;
    logic [7:0]         csum_total;
`endif

    logic xfer;
    logic last_byte;
    logic mem_we;

    // A byte moves only when offered and accepted on the same edge
    assign xfer      = in_valid && in_ready;
    // cnt is 5 bits, so N = 32 ends at cnt = 31 just like any shorter load
    assign last_byte = (8'(cnt_q) == (len_q - 8'd1));

    // State register plus loader bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LEN;
            cnt_q   <= '0;
            len_q   <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Next-state logic: length check, byte counting and the optional checksum
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        csum_total = sum_q + in_data;
`endif
        case (state_q)
            ST_LEN: begin
                if (xfer) begin
                    len_d   = in_data;
                    cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                    state_d = len_is_legal(in_data) ? ST_DATA : ST_ERR;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    cnt_d = cnt_q + IMEM_AW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + in_data;
                    if (last_byte) begin
                        state_d = ST_CSUM;
                    end
`else
                    if (last_byte) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) begin
                    state_d = (csum_total == 8'h00) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
        // Status flags rise on the edge of the final transfer
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
    end

    // Outputs: in_ready depends on state alone, never on in_valid
    always_comb begin
        in_ready = (state_q == ST_LEN) || (state_q == ST_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                   || (state_q == ST_CSUM)
`endif
                   ;
        mem_we   = xfer && (state_q == ST_DATA);
        done     = done_q;
        cpu_run  = done_q;
        err      = err_q;
    end

    imem_byte_array u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (cnt_q),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (instr)
    );

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Scoreboard bench for imem_loader. Stimulus pushes expected
//                fetch/status values; a monitor pops and compares on negedge.
//                Follows IMEM_LOADER_CHECKSUM_EN to pick the stream format.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [4:0]  rd_addr;
    logic [31:0] instr;
    logic        done;
    logic        cpu_run;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] instr;
        logic        rdy;
        logic        dn;
        logic        er;
    } exp_t;

    exp_t sb[$];

    imem_loader #(.IMEM_BYTES(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .instr    (instr),
        .done     (done),
        .cpu_run  (cpu_run),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the oldest queued expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (instr !== e.instr || in_ready !== e.rdy || done !== e.dn ||
                    cpu_run !== e.dn || err !== e.er) begin
                    errors++;
                    $display("FAIL %s addr=%0d: got instr=%h ready=%b done=%b cpu_run=%b err=%b, want instr=%h ready=%b done=%b err=%b",
                             e.name, e.addr, instr, in_ready, done, cpu_run, err,
                             e.instr, e.rdy, e.dn, e.er);
                end
            end
        end
    end

    task automatic expect_out(input string nm, input logic [4:0] a, input logic [31:0] ins,
                              input logic rdy, input logic dn, input logic er);
        exp_t e;
        rd_addr = a;
        e.name = nm; e.addr = a; e.instr = ins; e.rdy = rdy; e.dn = dn; e.er = er;
        sb.push_back(e);
        for (int k = 0; k < 4 && sb.size() != 0; k++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL %s: monitor never consumed expectation (pending=%0d, want 0)", nm, sb.size());
            sb.delete();
        end
    endtask

    // Offer one byte after 'gap' idle cycles; bounded wait for in_ready
    task automatic send(input logic [7:0] b, input int gap);
        int k;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready=%b for byte %h, want 1", in_ready, b);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Offer a byte for one cycle regardless of in_ready (should be ignored)
    task automatic poke(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int maxgap);
        foreach (s[i]) send(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    logic [7:0] stream[$];

    initial begin : stim
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rd_addr  = 5'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset: ready, nothing done, store all zero
        for (int a = 0; a < 32; a++) expect_out("reset_idle", 5'(a), 32'h0, 1'b1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 04 01 02 03 04 + F6: sum 0x0A + 0xF6 wraps to zero -> DONE
        stream = {8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
        send_stream(stream, 0);
        expect_out("csum_wait", 5'd0, 32'h01020304, 1'b1, 1'b0, 1'b0);
        send(8'hF6, 0);
        expect_out("csum_ok", 5'd0, 32'h01020304, 1'b0, 1'b1, 1'b0);
        do_reset();
        // Same data with F5 leaves residue 0xFF -> ERR, data still fetched
        stream = {8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
        send_stream(stream, 0);
        expect_out("csum_bad", 5'd0, 32'h01020304, 1'b0, 1'b0, 1'b1);
        do_reset();
`else
        // Eight transfers of the nine-byte stream: not done yet, writes already visible
        stream = {8'h08, 8'h20, 8'h04, 8'h00, 8'h05, 8'h00, 8'h85, 8'h30};
        send_stream(stream, 0);
        expect_out("load8_partial", 5'd0, 32'h20040005, 1'b1, 1'b0, 1'b0);
        send(8'h20, 0);
        expect_out("load8_w0", 5'd0, 32'h20040005, 1'b0, 1'b1, 1'b0);
        expect_out("load8_w1", 5'd4, 32'h00853020, 1'b0, 1'b1, 1'b0);
        expect_out("load8_w2", 5'd8, 32'h00000000, 1'b0, 1'b1, 1'b0);
        poke(8'hFF);
        expect_out("done_ignores", 5'd8, 32'h00000000, 1'b0, 1'b1, 1'b0);
        do_reset();
`endif

        // Illegal length 06 -> ERR, later bytes ignored
        send(8'h06, 0);
        expect_out("len06_err", 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        poke(8'h00);
        poke(8'h21);
        expect_out("err_ignores", 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        do_reset();
        send(8'h24, 0);
        expect_out("len36_err", 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        do_reset();
        send(8'h00, 0);
        expect_out("len0_err", 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        do_reset();

        // Full 32-byte load of 00..1F, no gaps then random gaps
        for (int pass = 0; pass < 2; pass++) begin
            stream = {};
            stream.push_back(8'h20);
            for (int i = 0; i < 32; i++) stream.push_back(8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
            stream.push_back(8'h10);   // 0..31 sums to 0xF0
`endif
            send_stream(stream, (pass == 0) ? 0 : 3);
            expect_out("full_wrap30", 5'd30, 32'h1E1F0001, 1'b0, 1'b1, 1'b0);
            expect_out("full_w0",     5'd0,  32'h00010203, 1'b0, 1'b1, 1'b0);
            expect_out("full_w28",    5'd28, 32'h1C1D1E1F, 1'b0, 1'b1, 1'b0);
            expect_out("full_odd13",  5'd13, 32'h0D0E0F10, 1'b0, 1'b1, 1'b0);
            do_reset();
        end

        // Reset part-way through a load clears everything
        stream = {8'h08, 8'h11, 8'h22, 8'h33};
        send_stream(stream, 0);
        expect_out("abort_partial", 5'd0, 32'h11223300, 1'b1, 1'b0, 1'b0);
        do_reset();
        for (int a = 0; a < 32; a += 4) expect_out("abort_cleared", 5'(a), 32'h0, 1'b1, 1'b0, 1'b0);
        stream = {8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(8'hF2);       // AA+BB+CC+DD = 0x30E
`endif
        send_stream(stream, 0);
        expect_out("reload_w0", 5'd0, 32'hAABBCCDD, 1'b0, 1'b1, 1'b0);
        expect_out("reload_w1", 5'd4, 32'h00000000, 1'b0, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
